// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load (redirect) beats increment.
// Also exposes the next-cycle value so the request address can be registered from it.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned          WIDTH    = 32,
    parameter logic [WIDTH-1:0]     RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] target,
    input  logic             inc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = target;
        end else if (inc) begin
            // Wraps modulo 2^WIDTH; targets are taken as-is with no alignment check.
            pc_d = pc_q + WIDTH'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc      = pc_q;
    assign pc_next = pc_d;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage: one outstanding imem request, single-entry output buffer, redirects.
// Handshakes: imem_req/imem_ack complete when both are 1 on a rising edge; if_valid/if_ready likewise.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned          WIDTH    = 32,
    parameter logic [WIDTH-1:0]     RESET_PC = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr,
    input  logic             if_ready,
    output fetch_state_t     dbg_state
);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic             pc_load;
    logic             pc_inc;
    logic             capture;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] addr_d;
    logic [WIDTH-1:0] if_pc_q;
    logic [WIDTH-1:0] if_pc_d;
    logic [WIDTH-1:0] if_instr_q;
    logic [WIDTH-1:0] if_instr_d;

    fetch_pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .load    (pc_load),
        .target  (redirect_target),
        .inc     (pc_inc),
        .pc      (pc),
        .pc_next (pc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                end else if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    // Without an ack the request is still in flight and must be drained.
                    pc_load = 1'b1;
                    state_d = imem_ack ? FETCH : DRAIN;
                end else if (imem_ack) begin
                    capture = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = run ? FETCH : IDLE;
                end else if (if_ready) begin
                    state_d = run ? FETCH : IDLE;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                end else if (imem_ack) begin
                    state_d = run ? FETCH : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state_q == FETCH) || (state_q == DRAIN);
        if_valid  = (state_q == HOLD);
        dbg_state = state_q;
    end

    // The request address holds the stale address while draining; otherwise it tracks pc.
    always_comb begin
        addr_d     = (state_d == DRAIN) ? addr_q : pc_next;
        if_pc_d    = capture ? pc : if_pc_q;
        if_instr_d = capture ? imem_rdata : if_instr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= RESET_PC;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            addr_q     <= addr_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign imem_addr = addr_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a latency-programmable memory model.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        run;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    fetch_state_t dbg_state;

    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ack2;
    logic [31:0] imem_rdata2;
    logic        if_valid2;
    logic [31:0] if_pc2;
    logic [31:0] if_instr2;
    fetch_state_t dbg_state2;

    int n_checks;
    int n_errors;
    int wait_cnt;
    int mem_lat;

    fetch_sequencer #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .run(run),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_ready(if_ready), .dbg_state(dbg_state)
    );

    // Second instance exercises pc wrap; its memory always answers with zero wait states.
    fetch_sequencer #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .run(run),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
        .if_valid(if_valid2), .if_pc(if_pc2), .if_instr(if_instr2),
        .if_ready(if_ready), .dbg_state(dbg_state2)
    );

    assign imem_ack2 = imem_req2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_mem();
        imem_ack   = imem_req && (wait_cnt >= mem_lat);
        imem_rdata = instr_of(imem_addr);
    endtask

    // One clock: DUT samples at the edge, bench observes and re-drives 1ns later.
    task automatic tick();
        logic fire;
        logic busy;
        fire = imem_req && imem_ack;
        busy = imem_req;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (rst || fire) wait_cnt = 0;
        else if (busy) wait_cnt = wait_cnt + 1;
        drive_mem();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wait_cnt = 0;
        drive_mem();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        wait_cnt = 0;
        mem_lat = 0;
        rst = 1'b1;
        run = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        if_ready = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = '0;
        imem_rdata2 = 32'hCAFE_F00D;

        // Reset values, zero-wait streaming, pc wrap on the second instance
        apply_reset();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_addr_wrap", imem_addr2, 32'hFFFF_FFFC);
        run = 1'b1;
        tick();
        check("f0_req", 32'(imem_req), 32'd1);
        check("f0_addr", imem_addr, 32'h0);
        check("f0_valid", 32'(if_valid), 32'd0);
        check("wrap_f0_addr", imem_addr2, 32'hFFFF_FFFC);
        tick();
        check("h0_valid", 32'(if_valid), 32'd1);
        check("h0_pc", if_pc, 32'h0);
        check("h0_instr", if_instr, instr_of(32'h0));
        check("h0_req", 32'(imem_req), 32'd0);
        check("wrap_h0_pc", if_pc2, 32'hFFFF_FFFC);
        check("wrap_h0_instr", if_instr2, 32'hCAFE_F00D);
        tick();
        check("f1_addr", imem_addr, 32'h4);
        check("f1_valid", 32'(if_valid), 32'd0);
        check("wrap_f1_addr", imem_addr2, 32'h0);
        tick();
        check("h1_pc", if_pc, 32'h4);
        check("h1_valid", 32'(if_valid), 32'd1);
        tick();
        check("f2_addr", imem_addr, 32'h8);
        tick();
        check("h2_pc", if_pc, 32'h8);

        // Three-cycle-late ack: request held stable for four cycles
        apply_reset();
        mem_lat = 3;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("slow_req_%0d", i), 32'(imem_req), 32'd1);
            check($sformatf("slow_addr_%0d", i), imem_addr, 32'h0);
            tick();
        end
        check("slow_valid", 32'(if_valid), 32'd1);
        check("slow_instr", if_instr, instr_of(32'h0));

        // Redirect mid-fetch, ack two cycles later: drain then fetch target
        mem_lat = 2;
        tick();
        check("dr_fetch_addr", imem_addr, 32'h4);
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        tick();
        check("dr_state", 32'(dbg_state), 32'(DRAIN));
        check("dr_addr_held", imem_addr, 32'h4);
        check("dr_req", 32'(imem_req), 32'd1);
        tick();
        check("dr_addr_held2", imem_addr, 32'h4);
        check("dr_valid0", 32'(if_valid), 32'd0);
        tick();
        check("dr_valid1", 32'(if_valid), 32'd0);
        check("dr_next_addr", imem_addr, 32'h100);
        check("dr_next_state", 32'(dbg_state), 32'(FETCH));
        tick();
        tick();
        tick();
        check("dr_hold_pc", if_pc, 32'h100);
        check("dr_hold_instr", if_instr, instr_of(32'h100));

        // Redirect coinciding with ack: data dropped, next request at target
        mem_lat = 0;
        tick();
        check("ra_addr", imem_addr, 32'h104);
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        tick();
        check("ra_valid", 32'(if_valid), 32'd0);
        check("ra_state", 32'(dbg_state), 32'(FETCH));
        check("ra_addr2", imem_addr, 32'h200);
        tick();
        check("ra_hold_pc", if_pc, 32'h200);

        // Redirect during HOLD with if_ready=1: buffer flushed
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        if_ready = 1'b1;
        tick();
        check("rh_valid", 32'(if_valid), 32'd0);
        check("rh_addr", imem_addr, 32'h200);
        check("rh_req", 32'(imem_req), 32'd1);
        tick();
        check("rh_hold_pc", if_pc, 32'h200);

        // run=0 while holding: consumption returns to IDLE; redirect in IDLE
        run = 1'b0;
        if_ready = 1'b0;
        tick();
        check("stall_valid", 32'(if_valid), 32'd1);
        if_ready = 1'b1;
        tick();
        check("idle_state", 32'(dbg_state), 32'(IDLE));
        check("idle_req", 32'(imem_req), 32'd0);
        check("idle_valid", 32'(if_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        tick();
        check("idle_redir_state", 32'(dbg_state), 32'(IDLE));
        run = 1'b1;
        tick();
        check("idle_redir_addr", imem_addr, 32'h40);

        // Asynchronous reset pulse in the middle of a drain
        apply_reset();
        mem_lat = 5;
        tick();
        redirect_valid = 1'b1;
        redirect_target = 32'h300;
        tick();
        check("ar_pre_state", 32'(dbg_state), 32'(DRAIN));
        #2;
        rst = 1'b1;
        #1;
        check("ar_req", 32'(imem_req), 32'd0);
        check("ar_valid", 32'(if_valid), 32'd0);
        check("ar_addr", imem_addr, 32'h0);
        rst = 1'b0;
        wait_cnt = 0;
        mem_lat = 0;
        drive_mem();
        tick();
        check("ar_first_req", 32'(imem_req), 32'd1);
        check("ar_first_addr", imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
